cnn_iter_ctrl: RTL
==================

# cnn_iter_ctrl

Sequencing controller for the shared single-cell CNN update datapath (9-bit A/B/U/I operands, 18-bit X/Y state). It walks a ROWS×COLS cell grid in raster order, issues one cell per accepted handshake, and generates delayed write-backs into a ping-pong state memory. It repeats this for a requested number of iterations and stops early when an iteration changes no cell. It sits between the host start/done interface and the datapath plus state-RAM address logic.

## Interface
- ROWS, 8, grid height (≥1)
- COLS, 8, grid width (≥1)
- LAT, 2, fixed datapath latency in cycles from issue handshake to result (≥1)
- RW = max(1,$clog2(ROWS)), CW = max(1,$clog2(COLS)), derived
- One clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin job; sampled only in IDLE
- iters  in  8  iteration limit, latched at start
- busy  out  1  high in RUN/DRAIN/SWAP
- done  out  1  one-cycle completion pulse
- converged  out  1  job ended by no-change exit; held until next start
- iter_count  out  8  completed iterations; held until next start
- issue_valid  out  1  cell address valid to datapath
- issue_ready  in  1  datapath accepts this cycle
- issue_row / issue_col  out  RW / CW  cell being issued
- rd_bank  out  1  state bank the datapath reads
- res_changed  in  1  result differs from old state; meaningful only when wb_en=1
- wb_en  out  1  write result to state RAM
- wb_row / wb_col  out  RW / CW  write-back address
- wb_bank  out  1  bank written, always ~rd_bank

## Operation
- States: IDLE, RUN, DRAIN, SWAP, DONE.
- IDLE: start=1 latches iters and clears iter_count, converged and the dirty flag. If iters=0 → DONE, else → RUN with row=col=0.
- RUN: issue_valid=1. Fire = issue_valid & issue_ready. On fire, push {row,col} into the write-back delay line and advance in raster order (col first, wrap to 0, row+1). Fire on (ROWS-1,COLS-1) → DRAIN. Without fire, row/col are held.
- Delay line: it shifts every cycle regardless of issue_ready. wb_en/wb_row/wb_col emerge exactly LAT cycles after fire.
- wb_en & res_changed sets dirty.
- DRAIN: issue_valid=0. When no valid entry remains in the delay line and no wb_en is in the current cycle → SWAP.
- SWAP (one cycle): iter_count+1, rd_bank toggles.
  - If dirty=0 → DONE with converged=1.
  - Else if iter_count+1 = iters → DONE.
  - Else clear dirty, reset row/col to 0, → RUN.
- DONE: done=1 for one cycle, → IDLE.
- start outside IDLE is ignored. iter_count saturates at 255 and is bounded by iters.
- Reset values: state IDLE, busy 0, done 0, converged 0, iter_count 0, issue_valid 0, row/col 0, rd_bank 0, wb_en 0, wb_row/wb_col 0, wb_bank 1, delay-line valids 0, dirty 0.
- rd_bank is not reset between jobs. It carries over so the latest state bank stays readable.
- Reset mid-job aborts immediately: no wb_en after reset assertion and no done pulse.

## Timing
- Cycle 0: start in IDLE. Cycle 1: first issue_valid.
- With issue_ready held 1, one iteration takes ROWS·COLS RUN cycles, LAT DRAIN cycles and 1 SWAP cycle.
- done pulses at cycle 1 + N·(ROWS·COLS+LAT+1) for N completed iterations. With defaults this is 1+67N. For iters=0, done pulses at cycle 1.
- Each issue_ready=0 cycle in RUN adds exactly one cycle.
- rd_bank changes only on the SWAP→next edge. No fire and no wb_en occur in SWAP, so read and write banks never overlap within an iteration.
- Outputs are registered, except issue_valid, busy and done, which are decoded from state.

## Structure
- Package cnn_pkg: WIDTH=9 operand width, 2·WIDTH state width, state enum {IDLE,RUN,DRAIN,SWAP,DONE}, default ROWS/COLS.
- Sub-module cnn_wb_delay: LAT-deep shift register of {valid,row,col} with async active-low clear. It exposes the head entry and an any-valid flag.

## Test plan
- 8×8, LAT=2, iters=3, ready=1, res_changed=1 → 192 fires in raster order; wb_en 2 cycles after each fire; done at cycle 202; iter_count=3; converged=0; rd_bank toggled 3 times.
- Same setup, res_changed=0 throughout → exit after iteration 1: done at cycle 68, iter_count=1, converged=1.
- iters=0 → no issue_valid, done at cycle 1, iter_count=0.
- issue_ready low on every other cycle during iteration 1, iters=1 → issue_row/col held while stalled; 64 fires; wb_en count=64; done delayed exactly by the stall count.
- rst_n pulsed low mid-RUN at cell (3,5) → all outputs at reset values immediately; no further wb_en; a subsequent start restarts from (0,0) with rd_bank=0.
- start asserted during RUN and DONE → ignored; iters changed mid-job has no effect on the job in progress.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN cell-update sequencing controller.
// Operand/state widths describe the datapath this controller feeds.
package cnn_pkg;

    localparam int WIDTH    = 9;
    localparam int STATE_W  = 2 * WIDTH;
    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;
    localparam int DEF_LAT  = 2;

    typedef logic [WIDTH-1:0]   operand_t;
    typedef logic [STATE_W-1:0] cell_state_t;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        SWAP,
        DONE
    } ctrl_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cnn_iter_ctrl_if.sv
// Datapath-side bundle of the iteration controller: cell issue handshake,
// bank selects and the delayed write-back port into the ping-pong state RAM.
interface cnn_iter_ctrl_if #(
    parameter int RW = 3,
    parameter int CW = 3
);

    logic          issue_valid;
    logic          issue_ready;
    logic [RW-1:0] issue_row;
    logic [CW-1:0] issue_col;
    logic          rd_bank;
    logic          res_changed;
    logic          wb_en;
    logic [RW-1:0] wb_row;
    logic [CW-1:0] wb_col;
    logic          wb_bank;

    modport master (
        output issue_valid,
        input  issue_ready,
        output issue_row,
        output issue_col,
        output rd_bank,
        input  res_changed,
        output wb_en,
        output wb_row,
        output wb_col,
        output wb_bank
    );

    modport slave (
        input  issue_valid,
        output issue_ready,
        input  issue_row,
        input  issue_col,
        input  rd_bank,
        output res_changed,
        input  wb_en,
        input  wb_row,
        input  wb_col,
        input  wb_bank
    );

endinterface

// File: rtl/cnn_wb_delay.sv
// Fixed-latency shift register carrying issued cell addresses to the
// write-back port; the head entry is the registered write-back request.
module cnn_wb_delay #(
    parameter int LAT = 2,
    parameter int RW  = 3,
    parameter int CW  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_valid,
    input  logic [RW-1:0] push_row,
    input  logic [CW-1:0] push_col,
    output logic          head_valid,
    output logic [RW-1:0] head_row,
    output logic [CW-1:0] head_col,
    output logic          pending
);

    logic [LAT-1:0] vld;
    logic [RW-1:0]  rows [LAT];
    logic [CW-1:0]  cols [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                rows[i] <= '0;
                cols[i] <= '0;
            end
        end else begin
            vld[0]  <= push_valid;
            rows[0] <= push_row;
            cols[0] <= push_col;
            for (int i = 1; i < LAT; i++) begin
                vld[i]  <= vld[i-1];
                rows[i] <= rows[i-1];
                cols[i] <= cols[i-1];
            end
        end
    end

    assign head_valid = vld[LAT-1];
    assign head_row   = rows[LAT-1];
    assign head_col   = cols[LAT-1];

    // Entries still queued behind the head; once clear, the head is the last write-back.
    generate
        if (LAT > 1) begin : g_pending
            assign pending = |vld[LAT-2:0];
        end else begin : g_no_pending
            assign pending = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/cnn_iter_ctrl.sv
// Raster-order cell sequencer for the shared CNN update datapath: repeats
// grid sweeps over ping-pong state banks until the iteration limit or no change.
module cnn_iter_ctrl
    import cnn_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int LAT  = DEF_LAT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] iters,
    output logic       busy,
    output logic       done,
    output logic       converged,
    output logic [7:0] iter_count,
    cnn_iter_ctrl_if.master dp
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    ctrl_state_t   state;
    ctrl_state_t   state_next;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [7:0]    iters_q;
    logic          rd_bank;
    logic          dirty;
    logic          issue_valid;
    logic          fire;
    logic          last_cell;
    logic          last_iter;
    logic          head_valid;
    logic [RW-1:0] head_row;
    logic [CW-1:0] head_col;
    logic          pending;

    assign fire      = (state == RUN) && dp.issue_ready;
    assign last_cell = (row == LAST_ROW) && (col == LAST_COL);
    assign last_iter = (sat_inc8(iter_count) == iters_q);

    cnn_wb_delay #(
        .LAT (LAT),
        .RW  (RW),
        .CW  (CW)
    ) u_wb_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (fire),
        .push_row   (row),
        .push_col   (col),
        .head_valid (head_valid),
        .head_row   (head_row),
        .head_col   (head_col),
        .pending    (pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN leaves as soon as the head holds the final write-back, so SWAP never sees a wb_en.
    always_comb begin
        state_next  = state;
        issue_valid = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (iters == 8'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                issue_valid = 1'b1;
                busy        = 1'b1;
                if (dp.issue_ready && last_cell) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!pending) begin
                    state_next = SWAP;
                end
            end
            SWAP: begin
                busy = 1'b1;
                if (!dirty || last_iter) begin
                    state_next = DONE;
                end else begin
                    state_next = RUN;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row        <= '0;
            col        <= '0;
            iters_q    <= '0;
            iter_count <= '0;
            rd_bank    <= 1'b0;
            dirty      <= 1'b0;
            converged  <= 1'b0;
        end else begin
            if (head_valid && dp.res_changed) begin
                dirty <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        iters_q    <= iters;
                        iter_count <= '0;
                        converged  <= 1'b0;
                        dirty      <= 1'b0;
                        row        <= '0;
                        col        <= '0;
                    end
                end
                RUN: begin
                    if (dp.issue_ready) begin
                        if (col == LAST_COL) begin
                            col <= '0;
                            row <= (row == LAST_ROW) ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                // rd_bank is deliberately kept across jobs so the newest bank stays readable.
                SWAP: begin
                    iter_count <= sat_inc8(iter_count);
                    rd_bank    <= ~rd_bank;
                    if (!dirty) begin
                        converged <= 1'b1;
                    end else if (!last_iter) begin
                        dirty <= 1'b0;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dp.issue_valid = issue_valid;
    assign dp.issue_row   = row;
    assign dp.issue_col   = col;
    assign dp.rd_bank     = rd_bank;
    assign dp.wb_bank     = ~rd_bank;
    assign dp.wb_en       = head_valid;
    assign dp.wb_row      = head_row;
    assign dp.wb_col      = head_col;

endmodule
